// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable registered-read or first-word-fall-through
// output, synchronous flush, sticky overflow/underflow and exact occupancy.
// Status flags are registered from the next-state count so they always agree.
module sync_fifo #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 6,
  parameter int unsigned AEMPT = 1,
  parameter int unsigned AFULL = 32,
  parameter int unsigned FWFT  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DSIZE-1:0] data_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic             flush_i,
  output logic [DSIZE-1:0] q_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [ASIZE:0]   data_num_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned    DEPTH   = 32'd1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] ONE_L   = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] ZERO_L  = {(ASIZE+1){1'b0}};

  // Storage array; contents survive reset and flush, only pointers are cleared.
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           afull_q, afull_d;
  logic           aempty_q, aempty_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [ASIZE-1:0] waddr_s;
  logic [ASIZE-1:0] raddr_s;

  assign waddr_s = wptr_q[ASIZE-1:0];
  assign raddr_s = rptr_q[ASIZE-1:0];

  // Acceptance is judged on the registered flags of the current cycle, so a
  // read frees a slot only after the edge and a write at Full is always refused.
  always_comb begin
    wr_acc_s = wr_en_i & ~full_q;
    rd_acc_s = rd_en_i & ~empty_q;
  end

  // Next-state pointers, occupancy and sticky error flags; flush wins over access.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush_i) begin
      wptr_d  = ZERO_L;
      rptr_d  = ZERO_L;
      count_d = ZERO_L;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + ONE_L;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + ONE_L;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + ONE_L;
        2'b01:   count_d = count_q - ONE_L;
        default: count_d = count_q;
      endcase
      if (wr_en_i & full_q) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (rd_en_i & empty_q) begin
        unf_d = 1'b1;
      end else begin
        unf_d = unf_q;
      end
    end
  end

  // Status flags derived from the next count; thresholds compared at 32 bits
  // so an out-of-range threshold parameter cannot be truncated.
  always_comb begin
    full_d   = (count_d == DEPTH_L);
    empty_d  = (count_d == ZERO_L);
    afull_d  = (32'(count_d) >= AFULL);
    aempty_d = (32'(count_d) <= AEMPT);
  end

  // Control and status registers; reset discards all data immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= ZERO_L;
      rptr_q   <= ZERO_L;
      count_q  <= ZERO_L;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Array write port; a write in a flush cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s & ~flush_i) begin
      mem_q[waddr_s] <= data_i;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; valid whenever empty_o is low.
      assign q_o = mem_q[raddr_s];
    end else begin : g_regrd
      logic [DSIZE-1:0] q_q;

      // Registered read: load the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q_q <= {DSIZE{1'b0}};
        end else if (rd_acc_s & ~flush_i) begin
          q_q <= mem_q[raddr_s];
        end else begin
          q_q <= q_q;
        end
      end

      assign q_o = q_q;
    end
  endgenerate

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign data_num_o     = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one FWFT instance share the same
// stimulus and are compared every cycle against a queue-based reference model.
module tb_sync_fifo;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AE = 1;
  localparam int AF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] data = '0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic fl = 1'b0;

  logic [DW-1:0] q0, q1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0] num0, num1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mq0 = '0;
  bit movf = 1'b0;
  bit munf = 1'b0;

  sync_fifo #(.DSIZE(DW), .ASIZE(AW), .AEMPT(AE), .AFULL(AF), .FWFT(0)) u_reg (
    .clk_i(clk), .rst_i(rst), .data_i(data), .wr_en_i(wr), .rd_en_i(rd),
    .flush_i(fl), .q_o(q0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .data_num_o(num0),
    .overflow_o(ovf0), .underflow_o(unf0));

  sync_fifo #(.DSIZE(DW), .ASIZE(AW), .AEMPT(AE), .AFULL(AF), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .data_i(data), .wr_en_i(wr), .rd_en_i(rd),
    .flush_i(fl), .q_o(q1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .data_num_o(num1),
    .overflow_o(ovf1), .underflow_o(unf1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue obeying the acceptance rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mq0 = '0;
      movf = 1'b0;
      munf = 1'b0;
    end else if (fl) begin
      mq.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      int n;
      n = mq.size();
      if (wr && n == DEPTH) movf = 1'b1;
      if (rd && n == 0) munf = 1'b1;
      if (rd && n != 0) mq0 = mq.pop_front();
      if (wr && n != DEPTH) mq.push_back(data);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int n;
      n = mq.size();
      check("num0", 32'(num0), n);
      check("num1", 32'(num1), n);
      check("full0", 32'(full0), 32'(n == DEPTH));
      check("full1", 32'(full1), 32'(n == DEPTH));
      check("empty0", 32'(empty0), 32'(n == 0));
      check("empty1", 32'(empty1), 32'(n == 0));
      check("afull0", 32'(af0), 32'(n >= AF));
      check("afull1", 32'(af1), 32'(n >= AF));
      check("aempty0", 32'(ae0), 32'(n <= AE));
      check("aempty1", 32'(ae1), 32'(n <= AE));
      check("ovf0", 32'(ovf0), 32'(movf));
      check("ovf1", 32'(ovf1), 32'(movf));
      check("unf0", 32'(unf0), 32'(munf));
      check("unf1", 32'(unf1), 32'(munf));
      check("q_reg", 32'(q0), 32'(mq0));
      if (n != 0) check("q_fwft", 32'(q1), 32'(mq[0]));
    end
  end

  task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    wr = w;
    rd = r;
    fl = f;
    data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_num", 32'(num0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_aempty", 32'(ae0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_q", 32'(q0), 32'd0);
    rst = 1'b0;

    // fill and drain
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(i));
      if (i == 5) check("af_before6", 32'(af0), 32'd0);
      if (i == 6) begin
        check("af_at6", 32'(af0), 32'd1);
        check("num_at6", 32'(num0), 32'd6);
      end
    end
    check("full_at8", 32'(full0), 32'd1);
    check("num_at8", 32'(num0), 32'd8);
    step(1'b1, 1'b0, 1'b0, 16'h0099);
    check("ovf_9th", 32'(ovf0), 32'd1);
    check("num_9th", 32'(num0), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("fwft_head", 32'(q1), 32'(i));
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("drain_q", 32'(q0), 32'(i));
    end
    check("empty_drained", 32'(empty0), 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("unf_set", 32'(unf0), 32'd1);
    check("q_hold_unf", 32'(q0), 32'h0008);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("flush_ovf", 32'(ovf0), 32'd0);
    check("flush_unf", 32'(unf0), 32'd0);
    check("flush_num", 32'(num0), 32'd0);

    // simultaneous access at DataNum=4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0010 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(16'h0020 + i));
      check("wr_rd_num", 32'(num0), 32'd4);
      check("wr_rd_q", 32'(q0), (i < 4) ? 32'(16'h0010 + i) : 32'(16'h0020 + i - 4));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0040 + i));
    check("full_again", 32'(full0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0050);
    check("full_wrrd_num", 32'(num0), 32'd7);
    check("full_wrrd_ovf", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0077);
    check("empty_wrrd_num", 32'(num0), 32'd1);
    check("empty_wrrd_unf", 32'(unf0), 32'd1);

    // first-word-fall-through single word
    step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'hA5A5);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("fwft_empty", 32'(empty1), 32'd0);
    check("fwft_q", 32'(q1), 32'h0000A5A5);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("fwft_pop_empty", 32'(empty1), 32'd1);
    check("fwft_pop_num", 32'(num1), 32'd0);

    // asynchronous reset between edges at DataNum=5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0105);
    check("pre_rst_num", 32'(num0), 32'd5);
    wr = 1'b0;
    rd = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_num", 32'(num0), 32'd0);
    check("arst_empty", 32'(empty0), 32'd1);
    check("arst_aempty", 32'(ae0), 32'd1);
    check("arst_q", 32'(q0), 32'd0);
    check("arst_num_fwft", 32'(num1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'h0200);
    step(1'b1, 1'b0, 1'b1, 16'h0201);
    check("flush_wr_num", 32'(num0), 32'd0);
    check("flush_wr_empty", 32'(empty0), 32'd1);

    // randomized traffic in write-heavy, read-heavy and balanced phases
    for (int i = 0; i < 3000; i++) begin
      int ph;
      int pw;
      int pr;
      ph = (i / 250) % 3;
      pw = (ph == 0) ? 80 : ((ph == 1) ? 30 : 50);
      pr = (ph == 0) ? 30 : ((ph == 1) ? 80 : 50);
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr),
           1'($urandom_range(63) == 0), 16'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for audio/USB datapaths where producer and consumer share one clock domain. It generalises the dual-clock FIFO with a selectable read mode: registered-read or first-word-fall-through. It also adds a synchronous flush, sticky overflow/underflow error flags and an exact occupancy count. It sits between same-clock pipeline stages, for example between a packet parser and the I2S/TDM serialiser.

## Interface
Parameters:
- DSIZE, 32, data width in bits
- ASIZE, 6, address width; depth = 2^ASIZE words
- AEMPT, 1, AlmostEmpty threshold (asserted when count <= AEMPT)
- AFULL, 32, AlmostFull threshold (asserted when count >= AFULL); 1 <= AFULL <= 2^ASIZE
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- Clock  input  1  single clock; all logic on rising edge
- Reset  input  1  asynchronous, active-high reset
- Data  input  DSIZE  write data
- WrEn  input  1  write request
- RdEn  input  1  read request
- Flush  input  1  synchronous clear of contents and flags
- Q  output  DSIZE  read data
- Full  output  1  count == 2^ASIZE
- Empty  output  1  count == 0
- AlmostFull  output  1  count >= AFULL
- AlmostEmpty  output  1  count <= AEMPT
- DataNum  output  ASIZE+1  current occupancy, 0..2^ASIZE
- Overflow  output  1  sticky: write attempted while Full
- Underflow  output  1  sticky: read attempted while Empty

## Operation
- Storage: 2^ASIZE x DSIZE array. Write and read pointers are ASIZE+1-bit binary; the address is the low ASIZE bits, and both pointers wrap modulo 2^(ASIZE+1).
- Write accepted = WrEn & ~Full; read accepted = RdEn & ~Empty. Acceptance uses the registered flags of the current cycle.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with WrEn & RdEn: the read is accepted, the write is rejected, count becomes 2^ASIZE-1 and Overflow is set.
- Empty with WrEn & RdEn: the write is accepted, the read is rejected, count becomes 1 and Underflow is set.
- Full, Empty, AlmostFull, AlmostEmpty and DataNum are registered and computed from the next count, so all five are mutually consistent on every cycle.
- FWFT=0: on an accepted read, Q <= mem[raddr] and the read pointer advances. Q holds its value otherwise.
- FWFT=1: Q = mem[raddr] combinationally (distributed RAM). Q is valid whenever Empty=0. An accepted read pops the word, and the next word appears after the clock edge.
- Flush (synchronous, priority over WrEn/RdEn in the same cycle): pointers, count and Overflow/Underflow are cleared, and Empty/AlmostEmpty are set. The array contents are not cleared. In FWFT=0, Q holds.
- Overflow is set on WrEn & Full; Underflow is set on RdEn & Empty. Both stay high until Reset or Flush.
- Reset values: Q=0 (FWFT=0), DataNum=0, Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, Overflow=0, Underflow=0, pointers 0. In FWFT=1, Q is undefined while Empty=1.
- A Reset asserted mid-transfer discards all data immediately, without waiting for a clock edge.

## Timing
- Write at edge N: DataNum, Empty and the flags reflect it after edge N. The data is readable with RdEn in cycle N+1.
- FWFT=0 read latency: RdEn sampled at edge N gives Q valid after edge N; one cycle of latency.
- FWFT=1 read latency: 0. Q shows the head word in the same cycle Empty=0; RdEn at edge N advances Q after edge N.
- Back-to-back writes and reads sustain 1 word per clock in both modes with no bubbles. Pointer wrap-around has no bubble.

## Test plan
Configuration for all scenarios: DSIZE=16, ASIZE=3 (depth 8), AEMPT=1, AFULL=6.
- Fill and drain (FWFT=0): write 0x0001..0x0008, then read 8.
  - Full=1 after the 8th write, with DataNum=8 and AlmostFull=1 from the 6th write.
  - Q = 0x0001..0x0008 in order, each one cycle after its RdEn; Empty=1 after the 8th read.
- Overflow/underflow: a 9th write while Full leaves DataNum=8, sets Overflow=1 and leaves memory unchanged. RdEn while Empty sets Underflow=1. A Flush pulse clears both flags and gives DataNum=0.
- Simultaneous access:
  - At DataNum=4, WrEn+RdEn for 20 cycles keeps DataNum=4 with data in order across pointer wrap.
  - At Full, WrEn+RdEn gives DataNum=7 and Overflow=1.
  - At Empty, WrEn+RdEn gives DataNum=1 and Underflow=1.
- FWFT=1: a single write of 0xA5A5 gives Empty=0 and Q=0xA5A5 in the next cycle with no RdEn. RdEn then gives Empty=1 and DataNum=0.
- Reset and flush: assert Reset asynchronously (between edges) at DataNum=5. All outputs take their reset values immediately. Flush together with WrEn ignores the write and gives DataNum=0.
